// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: forwarding, load-use stall, branch flush and multi-cycle freeze.
// Optional macro HAZARD_PERF_CNT_EN adds the StallCycles / FlushEvents performance counters.
module pipeline_hazard_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int PERF_W     = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [4:0]        Rs1D,
    input  logic [4:0]        Rs2D,
    input  logic [4:0]        Rs1E,
    input  logic [4:0]        Rs2E,
    input  logic [4:0]        RdE,
    input  logic [4:0]        RdM,
    input  logic [4:0]        RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemtoRegE,
    input  logic              PCSrcE,
    input  logic              MCycleStartE,
    input  logic              MCycleDone,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              McBusy,
`ifdef HAZARD_PERF_CNT_EN
    output logic [PERF_W-1:0] StallCycles,
    output logic [PERF_W-1:0] FlushEvents,
`endif
    output logic              McTimeout
);

    localparam int                CNT_W   = 10;
    localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(MC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = 1;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } mc_state_t;

    mc_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             mc_stall;
    logic             lw_stall;
    logic             branch;

    // Multi-cycle handshake: MCycleStartE is a one-cycle issue pulse from Execute;
    // MCycleDone marks the cycle the result is valid and completes the operation,
    // even in the issue cycle. Done with no outstanding operation is ignored.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        mc_stall  = 1'b0;
        case (state_q)
            RUN: begin
                cnt_d = '0;
                if (MCycleStartE && !MCycleDone) begin
                    state_d  = MC_WAIT;
                    mc_stall = 1'b1;
                end
            end
            MC_WAIT: begin
                if (MCycleDone) begin
                    state_d = RUN;
                end else begin
                    mc_stall = 1'b1;
                    if (cnt_q == TO_LAST) begin
                        state_d   = RUN;
                        timeout_d = 1'b1;
                    end
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        lw_stall  = MemtoRegE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
        branch    = PCSrcE && (state_q == RUN);
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (!RESET) begin
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
                ForwardAE = 2'b10;
            end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
                ForwardAE = 2'b01;
            end
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
                ForwardBE = 2'b10;
            end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
                ForwardBE = 2'b01;
            end
            // The multi-cycle freeze dominates; a taken branch cancels a load-use stall.
            StallF = mc_stall || (lw_stall && !branch);
            StallD = mc_stall || (lw_stall && !branch);
            StallE = mc_stall;
            FlushM = mc_stall;
            FlushD = branch;
            FlushE = branch || (lw_stall && !mc_stall);
        end
    end

    assign McBusy    = (state_q == MC_WAIT);
    assign McTimeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [PERF_W-1:0] PERF_ONE = 1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            StallCycles <= '0;
            FlushEvents <= '0;
        end else begin
            if (StallF) StallCycles <= StallCycles + PERF_ONE;
            if (FlushD) FlushEvents <= FlushEvents + PERF_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl, built with MC_TIMEOUT=8.
// Define HAZARD_PERF_CNT_EN to also exercise the performance counters.
module tb_pipeline_hazard_ctrl;

    logic       CLK;
    logic       RESET;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, MemtoRegE, PCSrcE, MCycleStartE, MCycleDone;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       McBusy, McTimeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] StallCycles, FlushEvents;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [6:0] exp_q[$];

    logic [5:0] ctl;
    assign ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM};

    pipeline_hazard_ctrl #(.MC_TIMEOUT(8), .PERF_W(16)) dut (
        .CLK(CLK), .RESET(RESET),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
        .PCSrcE(PCSrcE), .MCycleStartE(MCycleStartE), .MCycleDone(MCycleDone),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .McBusy(McBusy),
`ifdef HAZARD_PERF_CNT_EN
        .StallCycles(StallCycles), .FlushEvents(FlushEvents),
`endif
        .McTimeout(McTimeout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0;
        RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
        PCSrcE = 0; MCycleStartE = 0; MCycleDone = 0;
    endtask

    initial begin
        // Reset with hazards present: every control must stay low.
        clear_inputs();
        RESET = 1'b1;
        MemtoRegE = 1; RdE = 7; Rs2D = 7; PCSrcE = 1;
        RegWriteM = 1; RdM = 5; Rs1E = 5;
        tick();
        tick();
        #1;
        check("rst_ctl", 32'(ctl), 0);
        check("rst_fwd", 32'({ForwardAE, ForwardBE}), 0);
        check("rst_busy", 32'(McBusy), 0);
        check("rst_timeout", 32'(McTimeout), 0);
        RESET = 1'b0;
        clear_inputs();
        tick();

        // Forwarding
        RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 5;
        #1 check("fwd_m", 32'({ForwardAE, ForwardBE}), 32'b1010);
        RegWriteM = 0;
        #1 check("fwd_w", 32'({ForwardAE, ForwardBE}), 32'b0101);
        RdW = 0;
        #1 check("fwd_none", 32'({ForwardAE, ForwardBE}), 32'b0000);
        RegWriteM = 1; RdM = 4; RegWriteW = 1; RdW = 6; Rs1E = 4; Rs2E = 6;
        #1 check("fwd_split", 32'({ForwardAE, ForwardBE}), 32'b1001);
        RdM = 0; Rs1E = 0; Rs2E = 0;
        #1 check("fwd_r0", 32'({ForwardAE, ForwardBE}), 32'b0000);
        clear_inputs();

        // Load-use stall for exactly one cycle
        tick();
        MemtoRegE = 1; RdE = 7; Rs2D = 7;
        #1 check("lw_rs2", 32'(ctl), 32'b110010);
        tick();
        clear_inputs();
        #1 check("lw_after", 32'(ctl), 0);
        MemtoRegE = 1; RdE = 9; Rs1D = 9;
        #1 check("lw_rs1", 32'(ctl), 32'b110010);
        RdE = 0; Rs1D = 0; Rs2D = 0;
        #1 check("lw_r0", 32'(ctl), 0);
        MemtoRegE = 0; RdE = 7; Rs2D = 7;
        #1 check("lw_noload", 32'(ctl), 0);
        clear_inputs();

        // Branch flush, and branch beating load-use
        PCSrcE = 1;
        #1 check("br", 32'(ctl), 32'b000110);
        MemtoRegE = 1; RdE = 7; Rs2D = 7;
        #1 check("br_lw", 32'(ctl), 32'b000110);
        clear_inputs();
        tick();

        // Multi-cycle op: start pulse, Done four cycles later, branch ignored while waiting
        exp_q.push_back(7'b0111001);
        exp_q.push_back(7'b1111001);
        exp_q.push_back(7'b1111001);
        exp_q.push_back(7'b1111001);
        exp_q.push_back(7'b1000000);
        exp_q.push_back(7'b0000000);
        for (int cyc = 0; cyc < 6; cyc++) begin
            logic [6:0] e;
            MCycleStartE = (cyc == 0);
            MCycleDone   = (cyc == 4);
            PCSrcE       = (cyc == 2);
            e = exp_q.pop_front();
            #1 check($sformatf("mc_seq%0d", cyc), 32'({McBusy, ctl}), 32'(e));
            tick();
        end
        clear_inputs();

        // Start and Done together: no stall, stays in RUN
        MCycleStartE = 1; MCycleDone = 1;
        #1 check("mc_single", 32'(ctl), 0);
        tick();
        clear_inputs();
        #1 check("mc_single_run", 32'(McBusy), 0);
        MCycleDone = 1;
        #1 check("done_in_run", 32'(ctl), 0);
        tick();
        clear_inputs();
        #1 check("done_in_run_busy", 32'(McBusy), 0);

        // Timeout with MC_TIMEOUT=8
        MCycleStartE = 1;
        tick();
        MCycleStartE = 0;
        for (int i = 0; i < 8; i++) begin
            #1 check($sformatf("to_busy%0d", i), 32'({McBusy, McTimeout}), 32'b10);
            tick();
        end
        #1 check("to_done", 32'({McBusy, McTimeout}), 32'b01);
        check("to_done_ctl", 32'(ctl), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1 check($sformatf("to_sticky%0d", i), 32'(McTimeout), 1);
        end

        // Second run aborted by RESET mid-wait
        MCycleStartE = 1;
        tick();
        MCycleStartE = 0;
        tick();
        tick();
        #1 check("run2_busy", 32'({McBusy, McTimeout}), 32'b11);
        RESET = 1'b1;
        #1 check("rst_mid_ctl", 32'(ctl), 0);
        tick();
        RESET = 1'b0;
        #1 check("rst_mid_state", 32'({McBusy, McTimeout}), 0);
        check("rst_mid_after_ctl", 32'(ctl), 0);

`ifdef HAZARD_PERF_CNT_EN
        // Performance counters: 3 load-use stalls and 2 branches
        RESET = 1'b1;
        tick();
        #1 check("perf_rst", 32'({StallCycles, FlushEvents}), 0);
        RESET = 1'b0;
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            MemtoRegE = 1; RdE = 3; Rs1D = 3;
            tick();
            clear_inputs();
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            PCSrcE = 1;
            tick();
            PCSrcE = 0;
            tick();
        end
        #1 check("perf_stall", 32'(StallCycles), 3);
        check("perf_flush", 32'(FlushEvents), 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline.
- Produces the stall, flush and forwarding controls for the F/D, D/E, E/M and M/W pipeline registers.
- Covers load-use stalls, taken-branch flushes, and the freeze while a multi-cycle (MUL/DIV) unit owns the Execute stage.
- Contains a small FSM and timeout counter for multi-cycle sequencing; all other outputs are combinational on state plus inputs.

Parameters:
- MC_TIMEOUT, 64: maximum number of MC_WAIT cycles before the timeout error is raised; legal range 2..1023.
- PERF_W, 32: width of the optional performance counters.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- Rs1D, Rs2D  in  5 each  source registers of the instruction in Decode.
- Rs1E, Rs2E  in  5 each  source registers of the instruction in Execute.
- RdE, RdM, RdW  in  5 each  destination registers in Execute, Memory and Writeback.
- RegWriteM, RegWriteW  in  1 each  register write enables in Memory and Writeback.
- MemtoRegE  in  1  instruction in Execute is a load.
- PCSrcE  in  1  branch or jump resolved taken in Execute.
- MCycleStartE  in  1  multi-cycle operation issued from Execute this cycle.
- MCycleDone  in  1  multi-cycle result valid this cycle.
- StallF, StallD, StallE  out  1 each  hold the PC, the F/D register and the D/E register.
- FlushD, FlushE, FlushM  out  1 each  zero the F/D, D/E and E/M registers.
- ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 = register file, 01 = W result, 10 = M result.
- McBusy  out  1  FSM is in MC_WAIT.
- McTimeout  out  1  sticky multi-cycle timeout error.

Behaviour:
- Reset
  - RESET high for one edge: state=RUN, timeout counter=0, McTimeout=0.
  - While RESET is high, all stall, flush and forward outputs are 0 (the pipeline registers self-reset).
  - RESET mid-MC_WAIT aborts the operation; the FSM returns to RUN on that edge.
- Forwarding (combinational)
  - ForwardAE=10 if RegWriteM and RdM!=0 and RdM==Rs1E.
  - Otherwise ForwardAE=01 if RegWriteW and RdW!=0 and RdW==Rs1E.
  - Otherwise ForwardAE=00.
  - M has priority over W.
  - ForwardBE follows the same rules using Rs2E.
- Load-use stall
  - lwStall = MemtoRegE and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
  - lwStall asserts StallF, StallD and FlushE for exactly one cycle.
- Branch flush
  - PCSrcE asserts FlushD and FlushE in the same cycle.
  - When lwStall and PCSrcE coincide, the branch wins: StallF=StallD=0, FlushD=FlushE=1.
- mcStall
  - Defined as (state==RUN and MCycleStartE and not MCycleDone) or (state==MC_WAIT and not MCycleDone).
  - mcStall asserts StallF, StallD, StallE and FlushM, which injects a bubble into Memory.
  - mcStall overrides the load-use stall.
  - PCSrcE is ignored while state==MC_WAIT.
- FSM
  - RUN to MC_WAIT on MCycleStartE and not MCycleDone.
  - RUN stays in RUN when MCycleStartE and MCycleDone arrive in the same cycle (single-cycle completion, no stall).
  - MC_WAIT to RUN on MCycleDone. Stalls drop in the Done cycle, so the result advances on that edge.
  - MC_WAIT to RUN when the counter reaches MC_TIMEOUT-1; McTimeout is set and held until RESET.
  - MCycleDone while in RUN without MCycleStartE is ignored.
- Timeout counter
  - Cleared on entry to MC_WAIT; increments each MC_WAIT cycle.
  - Saturates; never wraps.
- McBusy = (state==MC_WAIT).

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - Output ports StallCycles[PERF_W-1:0] and FlushEvents[PERF_W-1:0] exist.
  - StallCycles increments every cycle in which StallF=1.
  - FlushEvents increments every cycle in which FlushD=1.
  - Both counters reset to 0, wrap modulo 2^PERF_W, and are held at 0 while RESET is high.
- When undefined: these ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Forwarding: RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=5 -> ForwardAE=ForwardBE=10. Then RegWriteM=0 -> both 01. Then RdW=0 -> both 00.
- Load-use: MemtoRegE=1, RdE=7, Rs2D=7 for one cycle -> StallF=StallD=FlushE=1 for exactly one cycle; with RdE=0 -> no stall.
- Branch vs load-use: same load-use inputs plus PCSrcE=1 -> FlushD=FlushE=1, StallF=StallD=0.
- Multi-cycle: MCycleStartE pulse, MCycleDone 4 cycles later -> McBusy high for 4 cycles; StallF/D/E and FlushM high for 4 cycles and low in the Done cycle; state returns to RUN.
- Timeout: MC_TIMEOUT=8, start with no Done -> McBusy drops after 8 cycles, McTimeout=1 and stays 1 until RESET. Assert RESET mid-wait in a second run -> RUN and McTimeout=0 after the edge.
- Perf counters (HAZARD_PERF_CNT_EN): 3 load-use stalls and 2 branches -> StallCycles=3, FlushEvents=2.
